execute_stage: RTL and testbench
================================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have one clock, clk; reset is synchronous and active-high, named reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 alu_sel  in  3  result class: 0 NOP, 1 LOGIC, 2 SHIFT, 3 MOVE, 4 ARITH, 5 MULDIV.
REQ-005 alu_op  in  8  operation code from the ID/EX pipeline register.
REQ-006 src_data1, src_data2  in  32 each  operands (rs-side, rt-side / immediate).
REQ-007 wr_addr  in  5; wr_en  in  1  destination register address and enable, passed through.
REQ-008 hi_in, lo_in  in  32 each  current HI/LO values (forwarded by the pipeline).
REQ-009 cancel  in  1  flush; aborts any divide in progress.
REQ-010 ex_wr_addr  out  5; ex_wr_en  out  1; ex_wr_data  out  32  GPR write-back to EX/MEM register.
REQ-011 hilo_wr_en  out  1; hi_out, lo_out  out  32 each  HI/LO write request.
REQ-012 stall_req  out  1  high while a divide occupies the stage.

Function
REQ-013 alu_op codes SHALL be: AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SLL 0x7C, SRL 0x02, SRA 0x03, ADD 0x20, ADDU 0x21, SUB 0x22, SUBU 0x23, SLT 0x2A, SLTU 0x2B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B.
REQ-014 LOGIC/SHIFT/ARITH/MOVE results SHALL be combinational; shifts use src_data1[4:0] as amount on src_data2.
REQ-015 ADD/SUB SHALL produce wrap-around 32-bit results; signed overflow SHALL force ex_wr_en=0 (no write); ADDU/SUBU never suppress.
REQ-016 SLT SHALL compare signed, SLTU unsigned; result 32'd1 or 32'd0.
REQ-017 MFHI/MFLO SHALL drive ex_wr_data from hi_in/lo_in; MTHI/MTLO SHALL assert hilo_wr_en with the untouched half copied from hi_in/lo_in.
REQ-018 MULT (signed) / MULTU SHALL compute the 64-bit product combinationally; hi_out=product[63:32], lo_out=product[31:0], hilo_wr_en=1.
REQ-019 Divider FSM states SHALL be IDLE, BUSY, DONE.
REQ-020 IDLE: on alu_op DIV/DIVU and cancel=0, latch operands, go BUSY, stall_req=1 in that same cycle.
REQ-021 Divisor zero SHALL skip BUSY: go straight to DONE with quotient and remainder 0.
REQ-022 BUSY SHALL run restoring division, one quotient bit per cycle, 6-bit counter 0..31, exactly 32 cycles, stall_req=1 throughout.
REQ-023 DIV SHALL divide magnitudes; quotient negated if signs differ, remainder takes dividend sign; 0x80000000 / -1 gives quotient 0x80000000, remainder 0.
REQ-024 DONE: stall_req=0, hilo_wr_en=1, lo_out=quotient, hi_out=remainder for one cycle, then IDLE.
REQ-025 Total divide occupancy SHALL be 34 cycles: accept, 32 BUSY, DONE; stall_req high for exactly 33 cycles.
REQ-026 Inputs are held stable by the upstream pipeline register while stall_req=1; the FSM SHALL use only latched operands.
REQ-027 cancel=1 in any state SHALL return to IDLE next cycle, deassert stall_req, and suppress hilo_wr_en that cycle.
REQ-028 alu_sel=NOP or unknown alu_op SHALL drive ex_wr_data=0, hilo_wr_en=0; ex_wr_addr/ex_wr_en still pass through.
REQ-029 DIV/DIVU SHALL force ex_wr_en=0 (HI/LO only).

Reset
REQ-030 While reset=1 every output SHALL be 0, FSM SHALL enter IDLE, counter and latched operands cleared.
REQ-031 reset mid-divide SHALL abandon the operation with no HI/LO write.

Verification
REQ-032 ADD 0x7FFFFFFF + 1, wr_en=1 -> ex_wr_en=0; ADDU same -> ex_wr_data=0x80000000, ex_wr_en=1.
REQ-033 MULT 0xFFFFFFFE x 3 -> hi_out=0xFFFFFFFF, lo_out=0xFFFFFFFA, hilo_wr_en=1 same cycle.
REQ-034 DIV -7 / 2 -> stall_req high 33 cycles, DONE cycle lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF, hilo_wr_en=1 once.
REQ-035 DIVU 10 / 0 -> stall_req 1 cycle, next cycle hilo_wr_en=1, hi_out=lo_out=0.
REQ-036 DIVU 100 / 7, cancel=1 at BUSY cycle 10 -> stall_req low next cycle, no hilo_wr_en; new DIVU 100/7 gives lo_out=14, hi_out=2.
REQ-037 reset asserted at BUSY cycle 20 -> all outputs 0 next cycle, FSM IDLE, no HI/LO write.

Source files
------------

// File: rtl/execute_stage.sv
// ============================================================================
// execute_stage : EX stage of a MIPS-like pipeline (ALU, multiplier, 34-cycle
//                 restoring divider with stall/cancel).         Rev 1.0
// ============================================================================
`default_nettype none

module execute_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  alu_sel,
   input  logic [7:0]  alu_op,
   input  logic [31:0] src_data1,
   input  logic [31:0] src_data2,
   input  logic [4:0]  wr_addr,
   input  logic        wr_en,
   input  logic [31:0] hi_in,
   input  logic [31:0] lo_in,
   input  logic        cancel,
   output logic [4:0]  ex_wr_addr,
   output logic        ex_wr_en,
   output logic [31:0] ex_wr_data,
   output logic        hilo_wr_en,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out,
   output logic        stall_req
);

   localparam logic [2:0] c_SEL_LOGIC  = 3'd1;
   localparam logic [2:0] c_SEL_SHIFT  = 3'd2;
   localparam logic [2:0] c_SEL_MOVE   = 3'd3;
   localparam logic [2:0] c_SEL_ARITH  = 3'd4;
   localparam logic [2:0] c_SEL_MULDIV = 3'd5;

   localparam logic [7:0] c_OP_AND   = 8'h24;
   localparam logic [7:0] c_OP_OR    = 8'h25;
   localparam logic [7:0] c_OP_XOR   = 8'h26;
   localparam logic [7:0] c_OP_NOR   = 8'h27;
   localparam logic [7:0] c_OP_SLL   = 8'h7C;
   localparam logic [7:0] c_OP_SRL   = 8'h02;
   localparam logic [7:0] c_OP_SRA   = 8'h03;
   localparam logic [7:0] c_OP_ADD   = 8'h20;
   localparam logic [7:0] c_OP_ADDU  = 8'h21;
   localparam logic [7:0] c_OP_SUB   = 8'h22;
   localparam logic [7:0] c_OP_SUBU  = 8'h23;
   localparam logic [7:0] c_OP_SLT   = 8'h2A;
   localparam logic [7:0] c_OP_SLTU  = 8'h2B;
   localparam logic [7:0] c_OP_MFHI  = 8'h10;
   localparam logic [7:0] c_OP_MTHI  = 8'h11;
   localparam logic [7:0] c_OP_MFLO  = 8'h12;
   localparam logic [7:0] c_OP_MTLO  = 8'h13;
   localparam logic [7:0] c_OP_MULT  = 8'h18;
   localparam logic [7:0] c_OP_MULTU = 8'h19;
   localparam logic [7:0] c_OP_DIV   = 8'h1A;
   localparam logic [7:0] c_OP_DIVU  = 8'h1B;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } div_state_t;

   // ------------------------------------------------------------------------
   // Combinational datapath
   // ------------------------------------------------------------------------
   logic [31:0] w_sum, w_diff, w_sra;
   logic        w_add_ovf, w_sub_ovf, w_slt, w_sltu;
   logic [63:0] w_prod_s, w_prod_u;

   assign w_sum     = src_data1 + src_data2;
   assign w_diff    = src_data1 - src_data2;
   assign w_add_ovf = (src_data1[31] == src_data2[31]) && (w_sum[31]  != src_data1[31]);
   assign w_sub_ovf = (src_data1[31] != src_data2[31]) && (w_diff[31] != src_data1[31]);
   assign w_slt     = $signed(src_data1) < $signed(src_data2);
   assign w_sltu    = src_data1 < src_data2;
   assign w_sra     = 32'($signed(src_data2) >>> src_data1[4:0]);
   // Low 64 bits of a 64x64 product of sign-extended operands equal the signed 32x32 product.
   assign w_prod_s  = {{32{src_data1[31]}}, src_data1} * {{32{src_data2[31]}}, src_data2};
   assign w_prod_u  = {32'd0, src_data1} * {32'd0, src_data2};

   logic [31:0] w_res, w_hi, w_lo;
   logic        w_wen, w_hilo_en, w_div_start, w_div_signed;

   always_comb begin
      w_res        = 32'd0;
      w_wen        = wr_en;
      w_hilo_en    = 1'b0;
      w_hi         = 32'd0;
      w_lo         = 32'd0;
      w_div_start  = 1'b0;
      w_div_signed = 1'b0;
      case (alu_sel)
         c_SEL_LOGIC: begin
            case (alu_op)
               c_OP_AND: w_res = src_data1 & src_data2;
               c_OP_OR:  w_res = src_data1 | src_data2;
               c_OP_XOR: w_res = src_data1 ^ src_data2;
               c_OP_NOR: w_res = ~(src_data1 | src_data2);
               default:  w_res = 32'd0;
            endcase
         end
         c_SEL_SHIFT: begin
            case (alu_op)
               c_OP_SLL: w_res = src_data2 << src_data1[4:0];
               c_OP_SRL: w_res = src_data2 >> src_data1[4:0];
               c_OP_SRA: w_res = w_sra;
               default:  w_res = 32'd0;
            endcase
         end
         c_SEL_MOVE: begin
            case (alu_op)
               c_OP_MFHI: w_res = hi_in;
               c_OP_MFLO: w_res = lo_in;
               c_OP_MTHI: begin
                  w_hilo_en = 1'b1;
                  w_hi      = src_data1;
                  w_lo      = lo_in;
               end
               c_OP_MTLO: begin
                  w_hilo_en = 1'b1;
                  w_hi      = hi_in;
                  w_lo      = src_data1;
               end
               default: w_res = 32'd0;
            endcase
         end
         c_SEL_ARITH: begin
            case (alu_op)
               c_OP_ADD: begin
                  w_res = w_sum;
                  if (w_add_ovf) w_wen = 1'b0;
               end
               c_OP_ADDU: w_res = w_sum;
               c_OP_SUB: begin
                  w_res = w_diff;
                  if (w_sub_ovf) w_wen = 1'b0;
               end
               c_OP_SUBU: w_res = w_diff;
               c_OP_SLT:  w_res = {31'd0, w_slt};
               c_OP_SLTU: w_res = {31'd0, w_sltu};
               default:   w_res = 32'd0;
            endcase
         end
         c_SEL_MULDIV: begin
            case (alu_op)
               c_OP_MULT: begin
                  w_hilo_en = 1'b1;
                  w_hi      = w_prod_s[63:32];
                  w_lo      = w_prod_s[31:0];
               end
               c_OP_MULTU: begin
                  w_hilo_en = 1'b1;
                  w_hi      = w_prod_u[63:32];
                  w_lo      = w_prod_u[31:0];
               end
               c_OP_DIV: begin
                  w_wen        = 1'b0;
                  w_div_start  = 1'b1;
                  w_div_signed = 1'b1;
               end
               c_OP_DIVU: begin
                  w_wen       = 1'b0;
                  w_div_start = 1'b1;
               end
               default: w_res = 32'd0;
            endcase
         end
         default: w_res = 32'd0;
      endcase
   end

   // ------------------------------------------------------------------------
   // Restoring divider on operand magnitudes, signs fixed up on the way out
   // ------------------------------------------------------------------------
   div_state_t  state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic        negq_q, negq_d, negr_q, negr_d;
   logic        w_div_stall, w_div_wr;

   logic [31:0] w_a_mag, w_b_mag;
   logic [32:0] w_part, w_trial;
   logic        w_ge;

   assign w_a_mag = (w_div_signed && src_data1[31]) ? (~src_data1 + 32'd1) : src_data1;
   assign w_b_mag = (w_div_signed && src_data2[31]) ? (~src_data2 + 32'd1) : src_data2;
   assign w_part  = {rem_q, quo_q[31]};
   assign w_trial = w_part - {1'b0, dvs_q};
   assign w_ge    = w_part >= {1'b0, dvs_q};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 6'd0;
         rem_q   <= 32'd0;
         quo_q   <= 32'd0;
         dvs_q   <= 32'd0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      negq_d      = negq_q;
      negr_d      = negr_q;
      w_div_stall = 1'b0;
      w_div_wr    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (w_div_start && !cancel) begin
               w_div_stall = 1'b1;
               cnt_d       = 6'd0;
               rem_d       = 32'd0;
               dvs_d       = w_b_mag;
               if (src_data2 == 32'd0) begin
                  quo_d   = 32'd0;
                  negq_d  = 1'b0;
                  negr_d  = 1'b0;
                  state_d = S_DONE;
               end else begin
                  quo_d   = w_a_mag;
                  negq_d  = w_div_signed && (src_data1[31] ^ src_data2[31]);
                  negr_d  = w_div_signed && src_data1[31];
                  state_d = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            w_div_stall = 1'b1;
            rem_d       = w_ge ? w_trial[31:0] : w_part[31:0];
            quo_d       = {quo_q[30:0], w_ge};
            cnt_d       = cnt_q + 6'd1;
            if (cnt_q == 6'd31) state_d = S_DONE;
         end
         S_DONE: begin
            w_div_wr = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (cancel) begin
         state_d     = S_IDLE;
         w_div_stall = 1'b0;
         w_div_wr    = 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Output merge: divider result, flush suppression, reset forcing
   // ------------------------------------------------------------------------
   always_comb begin
      ex_wr_addr = wr_addr;
      ex_wr_en   = w_wen;
      ex_wr_data = w_res;
      hilo_wr_en = w_hilo_en;
      hi_out     = w_hi;
      lo_out     = w_lo;
      stall_req  = w_div_stall;
      if (w_div_wr) begin
         hilo_wr_en = 1'b1;
         hi_out     = negr_q ? (~rem_q + 32'd1) : rem_q;
         lo_out     = negq_q ? (~quo_q + 32'd1) : quo_q;
      end
      if (cancel) begin
         hilo_wr_en = 1'b0;
         hi_out     = 32'd0;
         lo_out     = 32'd0;
      end
      if (reset) begin
         ex_wr_addr = 5'd0;
         ex_wr_en   = 1'b0;
         ex_wr_data = 32'd0;
         hilo_wr_en = 1'b0;
         hi_out     = 32'd0;
         lo_out     = 32'd0;
         stall_req  = 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_execute_stage.sv
// ============================================================================
// tb_execute_stage : directed self-checking bench for execute_stage.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_execute_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  alu_sel;
   logic [7:0]  alu_op;
   logic [31:0] src_data1, src_data2, hi_in, lo_in;
   logic [4:0]  wr_addr;
   logic        wr_en, cancel;
   logic [4:0]  ex_wr_addr;
   logic        ex_wr_en, hilo_wr_en, stall_req;
   logic [31:0] ex_wr_data, hi_out, lo_out;

   int errors = 0;
   int checks = 0;

   execute_stage dut (
      .clk        (clk),
      .reset      (reset),
      .alu_sel    (alu_sel),
      .alu_op     (alu_op),
      .src_data1  (src_data1),
      .src_data2  (src_data2),
      .wr_addr    (wr_addr),
      .wr_en      (wr_en),
      .hi_in      (hi_in),
      .lo_in      (lo_in),
      .cancel     (cancel),
      .ex_wr_addr (ex_wr_addr),
      .ex_wr_en   (ex_wr_en),
      .ex_wr_data (ex_wr_data),
      .hilo_wr_en (hilo_wr_en),
      .hi_out     (hi_out),
      .lo_out     (lo_out),
      .stall_req  (stall_req)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] sel, input logic [7:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic we);
      alu_sel   = sel;
      alu_op    = op;
      src_data1 = a;
      src_data2 = b;
      wr_en     = we;
      wr_addr   = 5'd9;
   endtask

   // Issues a divide and observes 40 cycles; index 0 is the accept cycle.
   task automatic div_run(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int stalls, output int writes, output int wr_idx,
                          output logic [31:0] hi, output logic [31:0] lo);
      stalls = 0; writes = 0; wr_idx = -1; hi = '0; lo = '0;
      tick;
      drive(3'd5, op, a, b, 1'b1);
      for (int i = 0; i < 40; i++) begin
         if (i > 0) tick;
         #1;
         if (stall_req) stalls++;
         if (hilo_wr_en) begin
            writes++;
            wr_idx = i;
            hi = hi_out;
            lo = lo_out;
            drive(3'd0, 8'h00, 32'd0, 32'd0, 1'b0);
         end
      end
      drive(3'd0, 8'h00, 32'd0, 32'd0, 1'b0);
   endtask

   task automatic test_reset;
      reset = 1'b1; cancel = 1'b0;
      hi_in = 32'hAAAA_5555; lo_in = 32'h1234_5678;
      drive(3'd4, 8'h21, 32'd5, 32'd6, 1'b1);
      tick; tick; #1;
      checks++;
      if ({ex_wr_addr, ex_wr_en, ex_wr_data, hilo_wr_en, hi_out, lo_out, stall_req} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: addr=%0d en=%b data=%h hilo=%b hi=%h lo=%h stall=%b, required all 0",
                  ex_wr_addr, ex_wr_en, ex_wr_data, hilo_wr_en, hi_out, lo_out, stall_req);
      end
      tick;
      reset = 1'b0;
      #1;
      checks++;
      if (ex_wr_data !== 32'd11 || ex_wr_addr !== 5'd9 || ex_wr_en !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_addu: data=%h addr=%0d en=%b, required 0000000b 9 1",
                  ex_wr_data, ex_wr_addr, ex_wr_en);
      end
   endtask

   task automatic test_logic;
      logic [2:0]  sel[7] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2};
      logic [7:0]  ops[7] = '{8'h24, 8'h25, 8'h26, 8'h27, 8'h7C, 8'h02, 8'h03};
      logic [31:0] as[7]  = '{32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234,
                              32'd4, 32'd4, 32'd4};
      logic [31:0] bs[7]  = '{32'h0FF0_5678, 32'h0FF0_5678, 32'h0FF0_5678, 32'h0FF0_5678,
                              32'h8000_00F1, 32'h8000_00F1, 32'h8000_00F1};
      logic [31:0] ex[7]  = '{32'h00F0_1230, 32'hFFF0_567C, 32'hFF00_444C, 32'h000F_A983,
                              32'h0000_0F10, 32'h0800_000F, 32'hF800_000F};
      for (int i = 0; i < 7; i++) begin
         tick;
         drive(sel[i], ops[i], as[i], bs[i], 1'b1);
         #1;
         checks++;
         if (ex_wr_data !== ex[i] || ex_wr_en !== 1'b1 || hilo_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL logic_shift op=%h: data=%h en=%b hilo=%b, required %h 1 0",
                     ops[i], ex_wr_data, ex_wr_en, hilo_wr_en, ex[i]);
         end
      end
   endtask

   task automatic test_arith;
      logic [7:0]  ops[7] = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h2A, 8'h2B, 8'h20};
      logic [31:0] as[7]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'd5,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3};
      logic [31:0] bs[7]  = '{32'd1, 32'd1, 32'd1, 32'd7, 32'd1, 32'd1, 32'd4};
      logic [31:0] ex[7]  = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE,
                              32'd1, 32'd0, 32'd7};
      logic        en[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 7; i++) begin
         tick;
         drive(3'd4, ops[i], as[i], bs[i], 1'b1);
         #1;
         checks++;
         if (ex_wr_data !== ex[i] || ex_wr_en !== en[i]) begin
            errors++;
            $display("FAIL arith op=%h: data=%h en=%b, required %h %b",
                     ops[i], ex_wr_data, ex_wr_en, ex[i], en[i]);
         end
      end
   endtask

   task automatic test_move;
      tick; drive(3'd3, 8'h10, 32'd0, 32'd0, 1'b1); #1;
      checks++;
      if (ex_wr_data !== 32'hAAAA_5555) begin
         errors++; $display("FAIL mfhi: data=%h, required aaaa5555", ex_wr_data);
      end
      tick; drive(3'd3, 8'h12, 32'd0, 32'd0, 1'b1); #1;
      checks++;
      if (ex_wr_data !== 32'h1234_5678) begin
         errors++; $display("FAIL mflo: data=%h, required 12345678", ex_wr_data);
      end
      tick; drive(3'd3, 8'h11, 32'hDEAD_BEEF, 32'd0, 1'b0); #1;
      checks++;
      if (hilo_wr_en !== 1'b1 || hi_out !== 32'hDEAD_BEEF || lo_out !== 32'h1234_5678) begin
         errors++;
         $display("FAIL mthi: hilo=%b hi=%h lo=%h, required 1 deadbeef 12345678", hilo_wr_en, hi_out, lo_out);
      end
      tick; drive(3'd3, 8'h13, 32'h0BAD_F00D, 32'd0, 1'b0); #1;
      checks++;
      if (hilo_wr_en !== 1'b1 || hi_out !== 32'hAAAA_5555 || lo_out !== 32'h0BAD_F00D) begin
         errors++;
         $display("FAIL mtlo: hilo=%b hi=%h lo=%h, required 1 aaaa5555 0badf00d", hilo_wr_en, hi_out, lo_out);
      end
   endtask

   task automatic test_mult;
      tick; drive(3'd5, 8'h18, 32'hFFFF_FFFE, 32'd3, 1'b0); #1;
      checks++;
      if (hilo_wr_en !== 1'b1 || hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFFA || stall_req !== 1'b0) begin
         errors++;
         $display("FAIL mult: hilo=%b hi=%h lo=%h stall=%b, required 1 ffffffff fffffffa 0",
                  hilo_wr_en, hi_out, lo_out, stall_req);
      end
      tick; drive(3'd5, 8'h19, 32'hFFFF_FFFE, 32'd3, 1'b0); #1;
      checks++;
      if (hilo_wr_en !== 1'b1 || hi_out !== 32'h0000_0002 || lo_out !== 32'hFFFF_FFFA) begin
         errors++;
         $display("FAIL multu: hilo=%b hi=%h lo=%h, required 1 00000002 fffffffa", hilo_wr_en, hi_out, lo_out);
      end
   endtask

   task automatic test_nop;
      tick; drive(3'd0, 8'h20, 32'd3, 32'd4, 1'b1); #1;
      checks++;
      if (ex_wr_data !== 32'd0 || hilo_wr_en !== 1'b0 || ex_wr_en !== 1'b1 || ex_wr_addr !== 5'd9) begin
         errors++;
         $display("FAIL nop: data=%h hilo=%b en=%b addr=%0d, required 0 0 1 9",
                  ex_wr_data, hilo_wr_en, ex_wr_en, ex_wr_addr);
      end
      tick; drive(3'd1, 8'h55, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); #1;
      checks++;
      if (ex_wr_data !== 32'd0 || hilo_wr_en !== 1'b0) begin
         errors++;
         $display("FAIL unknown_op: data=%h hilo=%b, required 0 0", ex_wr_data, hilo_wr_en);
      end
   endtask

   task automatic test_div;
      int s, w, idx;
      logic [31:0] hi, lo;
      tick; cancel = 1'b1; drive(3'd5, 8'h1A, 32'd9, 32'd3, 1'b1); #1;
      checks++;
      if (ex_wr_en !== 1'b0 || stall_req !== 1'b0 || hilo_wr_en !== 1'b0) begin
         errors++;
         $display("FAIL div_cancel_idle: en=%b stall=%b hilo=%b, required 0 0 0", ex_wr_en, stall_req, hilo_wr_en);
      end
      drive(3'd0, 8'h00, 32'd0, 32'd0, 1'b0);
      cancel = 1'b0;
      div_run(8'h1A, 32'hFFFF_FFF9, 32'd2, s, w, idx, hi, lo);
      checks++;
      if (s !== 33 || w !== 1 || idx !== 33 || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL div_m7_2: stalls=%0d writes=%0d at=%0d lo=%h hi=%h, required 33 1 33 fffffffd ffffffff",
                  s, w, idx, lo, hi);
      end
   endtask

   task automatic test_div_zero;
      int s, w, idx;
      logic [31:0] hi, lo;
      div_run(8'h1B, 32'd10, 32'd0, s, w, idx, hi, lo);
      checks++;
      if (s !== 1 || w !== 1 || idx !== 1 || lo !== 32'd0 || hi !== 32'd0) begin
         errors++;
         $display("FAIL divu_by_zero: stalls=%0d writes=%0d at=%0d lo=%h hi=%h, required 1 1 1 0 0",
                  s, w, idx, lo, hi);
      end
   endtask

   task automatic test_cancel;
      int s, w, idx, wr;
      logic [31:0] hi, lo;
      tick; drive(3'd5, 8'h1B, 32'd100, 32'd7, 1'b1); #1;
      for (int i = 1; i <= 11; i++) begin
         tick; #1;
      end
      checks++;
      if (stall_req !== 1'b1) begin
         errors++; $display("FAIL cancel_busy10_stall: stall=%b, required 1", stall_req);
      end
      cancel = 1'b1;
      drive(3'd0, 8'h00, 32'd0, 32'd0, 1'b0);
      #1;
      checks++;
      if (hilo_wr_en !== 1'b0) begin
         errors++; $display("FAIL cancel_cycle_hilo: hilo=%b, required 0", hilo_wr_en);
      end
      tick; cancel = 1'b0; #1;
      checks++;
      if (stall_req !== 1'b0 || hilo_wr_en !== 1'b0) begin
         errors++;
         $display("FAIL cancel_next: stall=%b hilo=%b, required 0 0", stall_req, hilo_wr_en);
      end
      wr = 0;
      for (int i = 0; i < 40; i++) begin
         tick; #1;
         if (hilo_wr_en || stall_req) wr++;
      end
      checks++;
      if (wr !== 0) begin
         errors++; $display("FAIL cancel_no_write: activity_cycles=%0d, required 0", wr);
      end
      div_run(8'h1B, 32'd100, 32'd7, s, w, idx, hi, lo);
      checks++;
      if (s !== 33 || w !== 1 || lo !== 32'd14 || hi !== 32'd2) begin
         errors++;
         $display("FAIL divu_100_7: stalls=%0d writes=%0d lo=%h hi=%h, required 33 1 e 2", s, w, lo, hi);
      end
   endtask

   task automatic test_reset_mid_div;
      int s, w, idx, wr;
      logic [31:0] hi, lo;
      tick; drive(3'd5, 8'h1A, 32'h1234_5678, 32'd3, 1'b1); #1;
      for (int i = 1; i <= 21; i++) begin
         tick; #1;
      end
      reset = 1'b1;
      tick; #1;
      checks++;
      if ({ex_wr_addr, ex_wr_en, ex_wr_data, hilo_wr_en, hi_out, lo_out, stall_req} !== '0) begin
         errors++;
         $display("FAIL reset_mid_div_outputs: addr=%0d en=%b data=%h hilo=%b hi=%h lo=%h stall=%b, required all 0",
                  ex_wr_addr, ex_wr_en, ex_wr_data, hilo_wr_en, hi_out, lo_out, stall_req);
      end
      reset = 1'b0;
      drive(3'd0, 8'h00, 32'd0, 32'd0, 1'b0);
      #1;
      checks++;
      if (stall_req !== 1'b0 || hilo_wr_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_div_idle: stall=%b hilo=%b, required 0 0", stall_req, hilo_wr_en);
      end
      wr = 0;
      for (int i = 0; i < 40; i++) begin
         tick; #1;
         if (hilo_wr_en || stall_req) wr++;
      end
      checks++;
      if (wr !== 0) begin
         errors++; $display("FAIL reset_mid_div_no_write: activity_cycles=%0d, required 0", wr);
      end
      div_run(8'h1A, 32'h8000_0000, 32'hFFFF_FFFF, s, w, idx, hi, lo);
      checks++;
      if (s !== 33 || w !== 1 || idx !== 33 || lo !== 32'h8000_0000 || hi !== 32'd0) begin
         errors++;
         $display("FAIL div_min_by_m1: stalls=%0d writes=%0d at=%0d lo=%h hi=%h, required 33 1 33 80000000 0",
                  s, w, idx, lo, hi);
      end
   endtask

   initial begin
      test_reset;
      test_logic;
      test_arith;
      test_move;
      test_mult;
      test_nop;
      test_div;
      test_div_zero;
      test_cancel;
      test_reset_mid_div;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
